instr_exec: RTL

PDP-8 instruction execution unit, directly downstream of the instruction fetch/decode stage (`instr_decode`). It consumes the decoded `pdp_mem_opcode` / `pdp_op7_opcode` and the effective addresses, and performs the memory read-modify-write. It holds the accumulator (AC) and link (L), drives `stall` and `PC_value` back to the decoder, and owns a separate read/write port into main memory.

---
 rtl/instr_exec.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/instr_exec.sv
// PDP-8 execute stage: memory read-modify-write, operate group 1,
// AC/L state and PC redirect back to the decoder.
package pdp_pkg;
   localparam int PDP_AW = 12;

   typedef struct packed {
      logic AND;
      logic TAD;
      logic ISZ;
      logic DCA;
      logic JMS;
      logic JMP;
      logic [PDP_AW-1:0] mem_inst_addr;
   } pdp_mem_opcode_s;

   typedef struct packed {
      logic CLA;
      logic CLL;
      logic CMA;
      logic CML;
      logic IAC;
      logic RAR;
      logic RAL;
      logic RTR;
      logic RTL;
      logic HLT;
      logic NOP;
   } pdp_op7_opcode_s;
endpackage

module instr_exec
   import pdp_pkg::*;
#(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 12,
   parameter logic [ADDR_WIDTH-1:0] START_PC = 12'o0200
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  pdp_mem_opcode_s       pdp_mem_opcode,
   input  pdp_op7_opcode_s       pdp_op7_opcode,
   output logic                  stall,
   output logic [ADDR_WIDTH-1:0] PC_value,
   output logic                  exec_rd_req,
   output logic [ADDR_WIDTH-1:0] exec_rd_addr,
   input  logic [DATA_WIDTH-1:0] exec_rd_data,
   output logic                  exec_wr_req,
   output logic [ADDR_WIDTH-1:0] exec_wr_addr,
   output logic [DATA_WIDTH-1:0] exec_wr_data,
   output logic [DATA_WIDTH-1:0] ac_out,
   output logic                  link_out,
   output logic                  halted
);

   typedef enum logic [2:0] {
      S_IDLE, S_RD, S_RDWAIT, S_WR, S_DONE, S_HALT
   } state_e;

   localparam logic [ADDR_WIDTH-1:0] A_ONE = 1;
   localparam logic [ADDR_WIDTH-1:0] A_TWO = 2;
   localparam logic [DATA_WIDTH-1:0] D_ONE = 1;

   localparam int M_AND = 5;
   localparam int M_TAD = 4;
   localparam int M_ISZ = 3;
   localparam int M_DCA = 2;
   localparam int M_JMS = 1;
   localparam int M_JMP = 0;

   localparam int G_CLA = 8;
   localparam int G_CLL = 7;
   localparam int G_CMA = 6;
   localparam int G_CML = 5;
   localparam int G_IAC = 4;
   localparam int G_RAR = 3;
   localparam int G_RAL = 2;
   localparam int G_RTR = 1;
   localparam int G_RTL = 0;

   state_e                state_q, state_d;
   logic [5:0]            mop_q, mop_d;
   logic [8:0]            g1_q, g1_d;
   logic [ADDR_WIDTH-1:0] ea_q, ea_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [DATA_WIDTH-1:0] ac_q, ac_d;
   logic                  link_q, link_d;

   logic [5:0]            mop_in;
   logic [8:0]            g1_in;
   logic                  op7_any;
   logic                  mem_one;
   logic                  accept;
   logic [DATA_WIDTH:0]   tad_sum;
   logic [DATA_WIDTH:0]   op7_res;

   // Group-1 micro-ops on the 13-bit {L,AC}, in PDP-8 sequence order
   function automatic logic [DATA_WIDTH:0] op7_apply(
      input logic [8:0]            g,
      input logic                  l,
      input logic [DATA_WIDTH-1:0] a
   );
      logic [DATA_WIDTH:0] v;
      logic [DATA_WIDTH:0] inc;
      v = {l, a};
      if (g[G_CLA]) v[DATA_WIDTH-1:0] = '0;
      if (g[G_CLL]) v[DATA_WIDTH] = 1'b0;
      if (g[G_CMA]) v[DATA_WIDTH-1:0] = ~v[DATA_WIDTH-1:0];
      if (g[G_CML]) v[DATA_WIDTH] = ~v[DATA_WIDTH];
      inc = {1'b0, v[DATA_WIDTH-1:0]} + {1'b0, D_ONE};
      if (g[G_IAC]) begin
         v = {v[DATA_WIDTH] ^ inc[DATA_WIDTH], inc[DATA_WIDTH-1:0]};
      end
      if ($onehot(g[G_RAR:G_RTL])) begin
         unique case (1'b1)
            g[G_RAR]: v = {v[0], v[DATA_WIDTH:1]};
            g[G_RAL]: v = {v[DATA_WIDTH-1:0], v[DATA_WIDTH]};
            g[G_RTR]: v = {v[1:0], v[DATA_WIDTH:2]};
            g[G_RTL]: v = {v[DATA_WIDTH-2:0], v[DATA_WIDTH:DATA_WIDTH-1]};
            default: ;
         endcase
      end
      return v;
   endfunction

   assign mop_in = {pdp_mem_opcode.AND, pdp_mem_opcode.TAD,
                    pdp_mem_opcode.ISZ, pdp_mem_opcode.DCA,
                    pdp_mem_opcode.JMS, pdp_mem_opcode.JMP};
   assign g1_in = {pdp_op7_opcode.CLA, pdp_op7_opcode.CLL,
                   pdp_op7_opcode.CMA, pdp_op7_opcode.CML,
                   pdp_op7_opcode.IAC, pdp_op7_opcode.RAR,
                   pdp_op7_opcode.RAL, pdp_op7_opcode.RTR,
                   pdp_op7_opcode.RTL};
   assign op7_any = (|g1_in) | pdp_op7_opcode.HLT | pdp_op7_opcode.NOP;
   assign mem_one = $onehot(mop_in);
   // PC match keeps a stale decode from being executed twice
   assign accept  = (base_addr == pc_q) && (mem_one || op7_any);
   assign tad_sum = {1'b0, ac_q} + {1'b0, exec_rd_data};
   assign op7_res = op7_apply(g1_q, link_q, ac_q);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         mop_q   <= '0;
         g1_q    <= '0;
         ea_q    <= '0;
         base_q  <= '0;
         pc_q    <= START_PC;
         data_q  <= '0;
         ac_q    <= '0;
         link_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mop_q   <= mop_d;
         g1_q    <= g1_d;
         ea_q    <= ea_d;
         base_q  <= base_d;
         pc_q    <= pc_d;
         data_q  <= data_d;
         ac_q    <= ac_d;
         link_q  <= link_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (mem_one) begin
                  if (mop_in[M_AND] | mop_in[M_TAD] | mop_in[M_ISZ]) begin
                     state_d = S_RD;
                  end else if (mop_in[M_DCA] | mop_in[M_JMS]) begin
                     state_d = S_WR;
                  end else begin
                     state_d = S_DONE;
                  end
               end else if (pdp_op7_opcode.HLT) begin
                  state_d = S_HALT;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_RD:     state_d = S_RDWAIT;
         S_RDWAIT: state_d = mop_q[M_ISZ] ? S_WR : S_DONE;
         S_WR:     state_d = S_DONE;
         S_DONE:   state_d = S_IDLE;
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      mop_d  = mop_q;
      g1_d   = g1_q;
      ea_d   = ea_q;
      base_d = base_q;
      pc_d   = pc_q;
      data_d = data_q;
      ac_d   = ac_q;
      link_d = link_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               mop_d  = mem_one ? mop_in : '0;
               g1_d   = mem_one ? '0 : g1_in;
               ea_d   = pdp_mem_opcode.mem_inst_addr;
               base_d = base_addr;
            end
         end
         S_RDWAIT: begin
            data_d = exec_rd_data;
            if (mop_q[M_AND]) ac_d = ac_q & exec_rd_data;
            if (mop_q[M_TAD]) begin
               ac_d   = tad_sum[DATA_WIDTH-1:0];
               link_d = link_q ^ tad_sum[DATA_WIDTH];
            end
         end
         S_DONE: begin
            {link_d, ac_d} = op7_res;
            if (mop_q[M_DCA]) ac_d = '0;
            pc_d = base_q + A_ONE;
            if (mop_q[M_JMP]) pc_d = ea_q;
            if (mop_q[M_JMS]) pc_d = ea_q + A_ONE;
            if (mop_q[M_ISZ] && (&data_q)) pc_d = base_q + A_TWO;
         end
         default: ;
      endcase
   end

   always_comb begin
      stall        = (state_q != S_IDLE);
      PC_value     = pc_q;
      exec_rd_req  = (state_q == S_RD);
      exec_rd_addr = '0;
      exec_wr_req  = (state_q == S_WR);
      exec_wr_addr = '0;
      exec_wr_data = '0;
      ac_out       = ac_q;
      link_out     = link_q;
      halted       = (state_q == S_HALT);
      if (exec_rd_req) exec_rd_addr = ea_q;
      if (exec_wr_req) begin
         exec_wr_addr = ea_q;
         unique case (1'b1)
            mop_q[M_ISZ]: exec_wr_data = data_q + D_ONE;
            mop_q[M_DCA]: exec_wr_data = ac_q;
            mop_q[M_JMS]: exec_wr_data = DATA_WIDTH'(base_q + A_ONE);
            default: ;
         endcase
      end
   end

endmodule
